icache_ctrl: RTL and testbench

Sequencing FSM for a direct-mapped, one-word-per-line instruction cache. It owns the valid-bit RAM, tag RAM and data RAM; these RAMs have registered reads with 1-cycle latency and synchronous writes. The block serves CPU fetches, handles miss refills over a req/ready memory handshake, and performs a whole-cache invalidate sweep on flush (fence.i).

---
 rtl/icache_pkg.sv | 32 +++
 rtl/icache_flush_seq.sv | 28 ++
 rtl/icache_ctrl.sv | 175 +++++++++++++++++
 tb/tb_icache_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types, geometry and address helpers for the instruction cache controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package icache_pkg;

    localparam int ADDR_W  = 32;
    localparam int INDEX_W = 6;
    localparam int OFF_W   = 2;
    localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W;
    localparam int LINES   = 2 ** INDEX_W;

    localparam logic VALID_PRESENT = 1'b1;
    localparam logic VALID_ABSENT  = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_COMPARE,
        S_REFILL,
        S_FILL,
        S_FLUSH
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: INDEX_W];
    endfunction

endpackage

// File: rtl/icache_flush_seq.sv
// Invalidate-sweep line counter: walks every cache line once and flags the last one.
// Latency: index is valid in the same cycle en is high; done coincides with the last line.
// Backpressure: none; advances one line per enabled cycle.
module icache_flush_seq
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [INDEX_W-1:0] idx,
    output logic               done
);

    logic [INDEX_W-1:0] cnt;

    // Advance one line per sweep cycle; natural wrap returns the counter to 0 after the last line.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + INDEX_W'(1);
        end
    end

    assign idx  = cnt;
    assign done = en && (cnt == INDEX_W'(LINES - 1));

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped one-word-line I-cache sequencer: lookup, miss refill, whole-cache invalidate.
// Latency: hit acks 3 cycles after req is first seen (req cycle counted); miss acks the cycle after mem_ready.
// Backpressure: cpu held via cpu_stall; refill waits on mem_ready. ICACHE_PERF_CNT_EN adds hit/miss counters.
module icache_ctrl
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic [ADDR_W-1:0]  cpu_addr,
    output logic               cpu_ack,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_stall,
    input  logic               flush_req,
    output logic               flush_done,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic [31:0]        mem_rdata,
    output logic [INDEX_W-1:0] ram_index,
    output logic               valid_wr,
    output logic               valid_wdata,
    input  logic               valid_rd,
    output logic               tag_wr,
    output logic [TAG_W-1:0]   tag_wdata,
    input  logic [TAG_W-1:0]   tag_rd,
    output logic               data_wr,
    output logic [31:0]        data_wdata,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt,
`endif
    input  logic [31:0]        data_rd
);

    state_e             state_q;
    state_e             state_d;
    logic               flush_pend_q;
    logic [31:0]        fill_dat_q;
    logic [TAG_W-1:0]   cpu_tag;
    logic [INDEX_W-1:0] cpu_idx;
    logic               hit;
    logic               sweep_en;
    logic [INDEX_W-1:0] sweep_idx;
    logic               sweep_done;

    assign cpu_tag  = addr_tag(cpu_addr);
    assign cpu_idx  = addr_index(cpu_addr);
    assign hit      = valid_rd && (tag_rd == cpu_tag);
    assign sweep_en = (state_q == S_FLUSH);

    icache_flush_seq u_flush_seq (
        .clk  (clk),
        .rst  (rst),
        .en   (sweep_en),
        .idx  (sweep_idx),
        .done (sweep_done)
    );

    // State register plus the flush request that arrived while a fetch was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            flush_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE) begin
                flush_pend_q <= 1'b0;
            end else if (state_q != S_FLUSH && flush_req) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

    // Capture the refill word so FILL can write it and forward it to the CPU together.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_dat_q <= '0;
        end else if (state_q == S_REFILL && mem_ready) begin
            fill_dat_q <= mem_rdata;
        end
    end

    // Next state: a flush (new or pending) always wins over a fetch when idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (flush_req || flush_pend_q) begin
                    state_d = S_FLUSH;
                end else if (cpu_req) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP:  state_d = S_COMPARE;
            S_COMPARE: state_d = hit ? S_IDLE : S_REFILL;
            S_REFILL:  state_d = mem_ready ? S_FILL : S_REFILL;
            S_FILL:    state_d = S_IDLE;
            S_FLUSH:   state_d = sweep_done ? S_IDLE : S_FLUSH;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs: RAM index follows the fetch address except during the sweep; everything else is 0 by default.
    always_comb begin
        cpu_ack     = 1'b0;
        cpu_rdata   = '0;
        flush_done  = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        ram_index   = '0;
        valid_wr    = 1'b0;
        valid_wdata = VALID_ABSENT;
        tag_wr      = 1'b0;
        tag_wdata   = '0;
        data_wr     = 1'b0;
        data_wdata  = '0;
        case (state_q)
            S_IDLE: begin
                ram_index = cpu_req ? cpu_idx : '0;
            end
            S_LOOKUP: begin
                ram_index = cpu_idx;
            end
            S_COMPARE: begin
                ram_index = cpu_idx;
                if (hit) begin
                    cpu_ack   = 1'b1;
                    cpu_rdata = data_rd;
                end
            end
            S_REFILL: begin
                ram_index = cpu_idx;
                mem_req   = 1'b1;
                mem_addr  = {cpu_tag, cpu_idx, {OFF_W{1'b0}}};
            end
            S_FILL: begin
                ram_index   = cpu_idx;
                valid_wr    = 1'b1;
                valid_wdata = VALID_PRESENT;
                tag_wr      = 1'b1;
                tag_wdata   = cpu_tag;
                data_wr     = 1'b1;
                data_wdata  = fill_dat_q;
                cpu_ack     = 1'b1;
                cpu_rdata   = fill_dat_q;
            end
            S_FLUSH: begin
                ram_index   = sweep_idx;
                valid_wr    = 1'b1;
                valid_wdata = VALID_ABSENT;
                flush_done  = sweep_done;
            end
            default: ;
        endcase
        cpu_stall = (state_q != S_IDLE) || (cpu_req && !cpu_ack);
    end

`ifdef ICACHE_PERF_CNT_EN
    // Classify each lookup at the COMPARE decision; a flush leaves the totals alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_q == S_COMPARE) begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: behavioural RAMs and memory, plus a line-level cache model.
// Latency: n/a (testbench).
// Backpressure: drives mem_ready after a chosen number of REFILL cycles.
module tb_icache_ctrl;
    import icache_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               cpu_req;
    logic [ADDR_W-1:0]  cpu_addr;
    logic               cpu_ack;
    logic [31:0]        cpu_rdata;
    logic               cpu_stall;
    logic               flush_req;
    logic               flush_done;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ready;
    logic [31:0]        mem_rdata;
    logic [INDEX_W-1:0] ram_index;
    logic               valid_wr;
    logic               valid_wdata;
    logic               valid_rd;
    logic               tag_wr;
    logic [TAG_W-1:0]   tag_wdata;
    logic [TAG_W-1:0]   tag_rd;
    logic               data_wr;
    logic [31:0]        data_wdata;
    logic [31:0]        data_rd;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]        hit_cnt;
    logic [31:0]        miss_cnt;
`endif

    always #5 clk = ~clk;

    icache_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .ram_index   (ram_index),
        .valid_wr    (valid_wr),
        .valid_wdata (valid_wdata),
        .valid_rd    (valid_rd),
        .tag_wr      (tag_wr),
        .tag_wdata   (tag_wdata),
        .tag_rd      (tag_rd),
        .data_wr     (data_wr),
        .data_wdata  (data_wdata),
`ifdef ICACHE_PERF_CNT_EN
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt),
`endif
        .data_rd     (data_rd)
    );

    // Cache RAMs: synchronous write, registered read (old contents on a same-edge collision).
    logic             vmem [LINES] = '{default: 1'b0};
    logic [TAG_W-1:0] tmem [LINES] = '{default: '0};
    logic [31:0]      dmem [LINES] = '{default: '0};

    always @(posedge clk) begin
        if (valid_wr) vmem[ram_index] <= valid_wdata;
        if (tag_wr)   tmem[ram_index] <= tag_wdata;
        if (data_wr)  dmem[ram_index] <= data_wdata;
        valid_rd <= vmem[ram_index];
        tag_rd   <= tmem[ram_index];
        data_rd  <= dmem[ram_index];
    end

    // Reference model: what each line should hold, and expected hit/miss totals.
    bit               rv   [LINES];
    logic [TAG_W-1:0] rt   [LINES];
    logic [31:0]      rdat [LINES];
    int               n_hit_m  = 0;
    int               n_miss_m = 0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        logic [INDEX_W-1:0] i;
        logic [TAG_W-1:0]   t;
        i = a[OFF_W +: INDEX_W];
        t = a[ADDR_W-1 : INDEX_W+OFF_W];
        return rv[i] && (rt[i] == t);
    endfunction

    // One fetch, starting in an idle cycle. Memory answers after `delay` REFILL cycles.
    task automatic fetch(input logic [31:0] a, input logic [31:0] word, input int delay, input bit flush_mid);
        logic [INDEX_W-1:0] idx;
        logic [TAG_W-1:0]   t;
        bit                 exp_hit;
        bit                 saw_mem;
        bit                 done;
        int                 cyc;
        int                 waitc;
        idx     = a[OFF_W +: INDEX_W];
        t       = a[ADDR_W-1 : INDEX_W+OFF_W];
        exp_hit = model_hit(a);
        saw_mem = 1'b0;
        done    = 1'b0;
        cyc     = 0;
        waitc   = 0;
        cpu_req  = 1'b1;
        cpu_addr = a;
        while (!done) begin
            @(negedge clk);
            cyc++;
            flush_req = 1'b0;
            if (mem_req) begin
                if (!saw_mem) check("mem_addr", mem_addr, {a[31:OFF_W], 2'b00});
                saw_mem = 1'b1;
                if (flush_mid && waitc == 0) flush_req = 1'b1;
                mem_ready = (waitc == delay);
                mem_rdata = word;
                waitc++;
            end else begin
                mem_ready = 1'b0;
            end
            if (cpu_ack) begin
                check("ack_latency", cyc, exp_hit ? 3 : 5 + delay);
                check("ack_data", cpu_rdata, exp_hit ? rdat[idx] : word);
                check("miss_went_to_mem", saw_mem, !exp_hit);
                check("ack_with_flush_done", flush_done, 0);
                if (exp_hit) begin
                    check("hit_no_write", {valid_wr, tag_wr, data_wr}, 0);
                    n_hit_m++;
                end else begin
                    check("fill_enables", {valid_wr, tag_wr, data_wr, valid_wdata}, 4'hF);
                    check("fill_idx_tag", {ram_index, tag_wdata}, {idx, t});
                    check("fill_data", data_wdata, word);
                    check("fill_mem_req_low", mem_req, 0);
                    n_miss_m++;
                    rv[idx]   = 1'b1;
                    rt[idx]   = t;
                    rdat[idx] = word;
                end
                done = 1'b1;
            end else if (cyc > 200) begin
                check("fetch_timeout", 1, 0);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        cpu_req   = 1'b0;
        mem_ready = 1'b0;
        flush_req = 1'b0;
    endtask

    // Invalidate sweep starting in the current idle cycle (fresh pulse or already pending).
    task automatic sweep(input bit pulse, input bit hold, input logic [31:0] a);
        if (pulse) flush_req = 1'b1;
        if (hold) begin
            cpu_req  = 1'b1;
            cpu_addr = a;
        end
        for (int k = 0; k < LINES; k++) begin
            @(posedge clk);
            #1;
            flush_req = 1'b0;
            @(negedge clk);
            check("sweep_enables", {valid_wr, valid_wdata, tag_wr, data_wr}, 4'b1000);
            check("sweep_index", ram_index, k);
            check("sweep_done", flush_done, k == LINES - 1);
            if (hold) check("sweep_cpu_stalled", {cpu_stall, cpu_ack}, 2'b10);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < LINES; i++) rv[i] = 1'b0;
    endtask

    // Abort a refill with reset; nothing may be written and the request must drop.
    task automatic reset_mid_refill(input logic [31:0] a);
        int n;
        n        = 0;
        cpu_req  = 1'b1;
        cpu_addr = a;
        @(negedge clk);
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_refill", mem_req, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_no_write", {valid_wr, tag_wr, data_wr}, 0);
        n_hit_m  = 0;
        n_miss_m = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          r;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        flush_req = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < LINES; i++) begin
            rv[i]   = 1'b0;
            rt[i]   = '0;
            rdat[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_controls", {cpu_ack, cpu_stall, mem_req, valid_wr, tag_wr, data_wr, flush_done, valid_wdata}, 0);
        check("reset_idx_addr", {ram_index, mem_addr}, 0);
        check("reset_rdata", cpu_rdata, 0);
        @(posedge clk);
        #1;

        // Cold miss, then hit, then conflict miss on the same line.
        fetch(32'h0000_0104, 32'hDEAD_BEEF, 5, 0);
        fetch(32'h0000_0104, 32'h0000_0000, 0, 0);
        fetch(32'h0000_1104, 32'h0BAD_F00D, 2, 0);
        check("conflict_tag_ram", tmem[1], 24'h000011);
        fetch(32'h0000_0104, 32'h1234_5678, 0, 0);

        // Full flush, then the line is gone.
        sweep(1, 0, 32'h0);
        fetch(32'h0000_0104, 32'hCAFE_F00D, 1, 0);

        // Flush arriving mid-refill: refill finishes, sweep follows, waiting fetch is served after.
        fetch(32'h0000_0208, 32'h2222_0208, 3, 1);
        sweep(0, 1, 32'h0000_0104);
        fetch(32'h0000_0104, 32'h5555_AAAA, 0, 0);

        reset_mid_refill(32'hABCD_0010);

        // Randomized traffic over a small address pool so hits and conflicts are frequent.
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) << (INDEX_W + OFF_W)) | ($urandom_range(0, 7) << OFF_W);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                sweep(1, 1, a);
                fetch(a, $urandom, $urandom_range(0, 4), 0);
            end else if (r == 1 && !model_hit(a)) begin
                fetch(a, $urandom, 3, 1);
                sweep(0, 0, 32'h0);
            end else begin
                fetch(a, $urandom, $urandom_range(0, 4), 0);
            end
        end

`ifdef ICACHE_PERF_CNT_EN
        check("hit_cnt", hit_cnt, n_hit_m);
        check("miss_cnt", miss_cnt, n_miss_m);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
